reservoir_lif_array: RTL and testbench
======================================

# reservoir_lif_array

Parametrised recurrent reservoir of leaky integrate-and-fire neurons with a programmable synaptic crossbar. It generalises the fixed 16-neuron/8-input crossbar to configurable neuron count, input count and weight/potential widths. It adds time-stepped sequential accumulation, a leak term, start/done handshaking and weight flush. It sits between the input spike encoder, which drives `ein_ext`, and the readout layer, which consumes `spike_record`.

## Interface
- `N_NEURONS`, 16: reservoir neurons (N).
- `N_EXT`, 8: external input lines (E).
- `W_WIDTH`, 8: signed synaptic weight width.
- `V_WIDTH`, 12: signed membrane potential width.
- `THRESH`, 64: firing threshold (positive).
- `LEAK_SHIFT`, 3: leak equals `v >>> LEAK_SHIFT`.
- `REFRACT`, 2: refractory length in steps (used only with the macro).
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  weight write strobe.
- `wr_row`  in  clog2(N+E)  presynaptic row: 0..N-1 are neurons, N..N+E-1 are external inputs.
- `wr_col`  in  clog2(N)  postsynaptic neuron.
- `wr_data`  in  W_WIDTH  signed weight.
- `flush_weight`  in  1  clears all weights to 0.
- `ein_ext`  in  E  external spikes for the next step; bit k feeds row N+k.
- `step_start`  in  1  begins one time step.
- `busy`  out  1  high from the cycle after an accepted start until `step_done`.
- `step_done`  out  1  one-cycle pulse at the end of a step.
- `spike_record`  out  N  spikes of the last completed step; bit j is neuron j.

## Operation
- FSM states are IDLE, ACCUM, UPDATE and DONE.
- IDLE → ACCUM on `step_start`:
  - latch `pre = {ein_ext, spike_record}`, with bit r = row r;
  - set row counter to 0;
  - set `busy` to 1.
- ACCUM, one row r per cycle: for every j, if `pre[r]`, then `acc[j] += W[r][j]`.
  - Add with saturation to the signed V_WIDTH range.
  - After row N+E-1, go to UPDATE.
- UPDATE, one cycle, for every j:
  - `v' = sat(v - (v >>> LEAK_SHIFT) + acc)`;
  - if `v' >= THRESH`, then spike, and v ← 0;
  - otherwise v ← v';
  - clear `acc`;
  - register the new `spike_record`.
- DONE, one cycle: `step_done` = 1 and `busy` = 0, then → IDLE.
- Weight writes: `wr_en` in IDLE writes `W[wr_row][wr_col]` at the edge. It is ignored in all other states.
- Flush: `flush_weight` in IDLE zeroes every weight in one cycle and takes priority over a simultaneous `wr_en`. It is ignored while busy.
- `step_start` while not IDLE is ignored.
- A simultaneous `step_start` and `wr_en` in IDLE performs both. The written weight is visible to this step.
- An out-of-range `wr_row`/`wr_col` write is dropped.
- Reset (sync, low):
  - all weights, `v`, `acc`, the refractory counters and `spike_record` go to 0;
  - `busy` = 0 and `step_done` = 0;
  - the FSM goes to IDLE.
  - Reset mid-step aborts the step with no `step_done`.

## Timing
- Accepted `step_start` at edge t gives `busy` = 1 from t+1.
- ACCUM occupies N+E cycles.
- `spike_record` updates at the UPDATE edge.
- `step_done` is high for the cycle after UPDATE. Latency from start to done is N+E+2 cycles (26 with defaults).
- A new `step_start` is accepted in the cycle after `step_done`, so steps can run back to back every N+E+3 cycles.

## Configuration
- `RESERVOIR_REFRACTORY_EN` defined:
  - a per-neuron counter loads REFRACT on a spike;
  - while the counter is nonzero, that neuron's UPDATE discards `acc`, holds v at 0, emits no spike, and decrements the counter.
- `RESERVOIR_REFRACTORY_EN` not defined:
  - no counters exist;
  - a neuron may fire on every step;
  - `REFRACT` is unused.

## Structure
- Package `reservoir_pkg`: FSM state enum, the weight and potential typedefs, and a `sat_add` function for signed saturating addition.
- Sub-module `reservoir_lif_neuron`: holds per-neuron `acc`, `v`, leak, threshold and the refractory counter. It is instantiated N times by generate.
- The top level keeps the FSM, row counter, weight array and write/flush logic.

## Test plan
All scenarios use defaults, with the macro undefined unless stated.
- Reset: hold `reset` = 0 for 2 cycles, then release → `spike_record` = 0, `busy` = 0, `step_done` = 0. The first step with no inputs gives `spike_record` = 0.
- Single drive: write `W[16][5]` = +100, `ein_ext` = 8'h01, pulse `step_start` → `step_done` exactly 26 cycles later, and only `spike_record[5]` = 1.
- Recurrence and refractory: as above plus `W[5][9]` = +100, with a second step and `ein_ext` = 0 → only neuron 9 fires.
  - With the macro and `ein_ext` held at 8'h01, neuron 5 stays silent for steps 2–3 and fires again at step 4.
- Leak: `W[16][0]` = +40, one step with `ein_ext` = 8'h01, then a step with `ein_ext` = 0 → no spikes, and neuron 0 v = 40 then 35.
- Saturation: all 24 rows drive neuron 0 with −128, all spikes on → v clamps at −2048 with no wrap, and the next positive drive raises it from −2048.
- Protocol: `wr_en`, `flush_weight` and `step_start` pulsed mid-ACCUM → no effect on weights or timing. Reset asserted mid-ACCUM → IDLE next cycle, no `step_done`, all outputs 0.

Source files
------------

// File: rtl/reservoir_pkg.sv
// Shared types and helpers for the LIF reservoir.
// The optional refractory behaviour is enabled by RESERVOIR_REFRACTORY_EN.
package reservoir_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_W_WIDTH = 8;
  localparam int DEF_V_WIDTH = 12;

  typedef logic signed [DEF_W_WIDTH-1:0] weight_t;
  typedef logic signed [DEF_V_WIDTH-1:0] potential_t;

  // Signed add clamped to the range of a 'width'-bit two's complement value.
  function automatic int sat_add(input int a, input int b, input int width);
    longint sum;
    longint hi;
    longint lo;
    sum = longint'(a) + longint'(b);
    hi  = (longint'(1) <<< (width - 1)) - 1;
    lo  = -(longint'(1) <<< (width - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return int'(sum);
  endfunction

endpackage

// File: rtl/reservoir_lif_neuron.sv
// One leaky integrate-and-fire neuron: synaptic accumulator, membrane
// potential with shift leak, threshold and (with RESERVOIR_REFRACTORY_EN)
// a refractory counter that mutes the neuron for REFRACT steps after a spike.
module reservoir_lif_neuron
  import reservoir_pkg::*;
#(
  parameter int W_WIDTH    = 8,
  parameter int V_WIDTH    = 12,
  parameter int THRESH     = 64,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               accum_en,
  input  logic [W_WIDTH-1:0] weight,
  input  logic               update_en,
  output logic               spike
);

  logic signed [V_WIDTH-1:0] acc;
  logic signed [V_WIDTH-1:0] v;
  int                        v_new;
  logic                      fire;
  logic                      in_refract;

  // Leak is subtracted first; it never overflows because it shares v's sign.
  always_comb begin
    v_new = sat_add(int'(v) - int'(v >>> LEAK_SHIFT), int'(acc), V_WIDTH);
    fire  = (v_new >= THRESH);
  end

`ifdef RESERVOIR_REFRACTORY_EN
  localparam int RCW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  logic [RCW-1:0] refr;

  assign in_refract = (refr != '0);

  // Refractory counter: loads on a spike, counts down one per step.
  always_ff @(posedge clock) begin
    if (!reset) begin
      refr <= '0;
    end else if (update_en) begin
      if (in_refract) begin
        refr <= refr - 1'b1;
      end else if (fire) begin
        refr <= RCW'(REFRACT);
      end
    end
  end
`else
  assign in_refract = 1'b0;
`endif

  // Accumulate weighted presynaptic spikes, then integrate/fire on update.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc   <= '0;
      v     <= '0;
      spike <= 1'b0;
    end else if (update_en) begin
      acc <= '0;
      if (in_refract) begin
        v     <= '0;
        spike <= 1'b0;
      end else if (fire) begin
        v     <= '0;
        spike <= 1'b1;
      end else begin
        v     <= V_WIDTH'(v_new);
        spike <= 1'b0;
      end
    end else if (accum_en) begin
      acc <= V_WIDTH'(sat_add(int'(acc), int'($signed(weight)), V_WIDTH));
    end
  end

endmodule

// File: rtl/reservoir_lif_array.sv
// Recurrent LIF reservoir: sequencing FSM, row counter, weight crossbar with
// write/flush, and N neuron instances. Define RESERVOIR_REFRACTORY_EN to give
// each neuron a REFRACT-step refractory period after firing.
module reservoir_lif_array
  import reservoir_pkg::*;
#(
  parameter int N_NEURONS  = 16,
  parameter int N_EXT      = 8,
  parameter int W_WIDTH    = 8,
  parameter int V_WIDTH    = 12,
  parameter int THRESH     = 64,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 2
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   wr_en,
  input  logic [$clog2(N_NEURONS+N_EXT)-1:0]     wr_row,
  input  logic [$clog2(N_NEURONS)-1:0]           wr_col,
  input  logic [W_WIDTH-1:0]                     wr_data,
  input  logic                                   flush_weight,
  input  logic [N_EXT-1:0]                       ein_ext,
  input  logic                                   step_start,
  output logic                                   busy,
  output logic                                   step_done,
  output logic [N_NEURONS-1:0]                   spike_record
);

  localparam int ROWS = N_NEURONS + N_EXT;
  localparam int RW   = $clog2(ROWS);

  state_t                      state;
  state_t                      next_state;
  logic [RW-1:0]               row_cnt;
  logic [ROWS-1:0]             pre;
  logic [N_NEURONS*W_WIDTH-1:0] weight_mem [ROWS];
  logic [N_NEURONS*W_WIDTH-1:0] row_weights;
  logic                        accum_en;
  logic                        update_en;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    step_done  = 1'b0;
    case (state)
      IDLE: begin
        if (step_start) next_state = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (row_cnt == RW'(ROWS - 1)) next_state = UPDATE;
      end
      UPDATE: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        step_done  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the presynaptic vector on start and walk one row per ACCUM cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      row_cnt <= '0;
      pre     <= '0;
    end else if (state == IDLE) begin
      if (step_start) begin
        row_cnt <= '0;
        pre     <= {ein_ext, spike_record};
      end
    end else if (state == ACCUM) begin
      row_cnt <= row_cnt + 1'b1;
    end
  end

  // Weight crossbar: writable only in IDLE; flush wins over a write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) weight_mem[r] <= '0;
    end else if (state == IDLE) begin
      if (flush_weight) begin
        for (int r = 0; r < ROWS; r++) weight_mem[r] <= '0;
      end else if (wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < N_NEURONS)) begin
        weight_mem[wr_row][int'(wr_col)*W_WIDTH +: W_WIDTH] <= wr_data;
      end
    end
  end

  assign row_weights = weight_mem[row_cnt];
  assign accum_en    = (state == ACCUM) && pre[row_cnt];
  assign update_en   = (state == UPDATE);

  generate
    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
      reservoir_lif_neuron #(
        .W_WIDTH   (W_WIDTH),
        .V_WIDTH   (V_WIDTH),
        .THRESH    (THRESH),
        .LEAK_SHIFT(LEAK_SHIFT),
        .REFRACT   (REFRACT)
      ) u_neuron (
        .clock    (clock),
        .reset    (reset),
        .accum_en (accum_en),
        .weight   (row_weights[gi*W_WIDTH +: W_WIDTH]),
        .update_en(update_en),
        .spike    (spike_record[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_reservoir_lif_array.sv
// Self-checking bench for reservoir_lif_array (default parameters).
// Works with or without RESERVOIR_REFRACTORY_EN defined.
module tb_reservoir_lif_array;
  import reservoir_pkg::*;

  localparam int N        = 16;
  localparam int E        = 8;
  localparam int ROWS     = N + E;
  localparam int LS       = 3;
  localparam int TH       = 64;
  localparam int VMAX     = 2047;
  localparam int VMIN     = -2048;
  localparam int STEP_LAT = N + E + 2;
  localparam int REFR_LEN = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [4:0]    wr_row = '0;
  logic [3:0]    wr_col = '0;
  logic [7:0]    wr_data = '0;
  logic          flush_weight = 1'b0;
  logic [7:0]    ein_ext = '0;
  logic          step_start = 1'b0;
  logic          busy;
  logic          step_done;
  logic [15:0]   spike_record;

  always #5 clock = ~clock;

  reservoir_lif_array dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .flush_weight(flush_weight),
    .ein_ext     (ein_ext),
    .step_start  (step_start),
    .busy        (busy),
    .step_done   (step_done),
    .spike_record(spike_record)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: weights, potentials, spikes and a step-phase counter.
  int            m_w [ROWS][N];
  int            m_v [N];
  int            m_refr [N];
  logic [15:0]   m_spk;
  logic [23:0]   m_pre;
  int            m_cnt;

  function automatic int clampv(input int x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  function automatic void model_step();
    for (int j = 0; j < N; j++) begin
      int acc;
      int vn;
      acc = 0;
      for (int r = 0; r < ROWS; r++)
        if (m_pre[r]) acc = clampv(acc + m_w[r][j]);
      vn = clampv(m_v[j] - (m_v[j] >>> LS) + acc);
`ifdef RESERVOIR_REFRACTORY_EN
      if (m_refr[j] > 0) begin
        m_refr[j] = m_refr[j] - 1;
        m_v[j]    = 0;
        m_spk[j]  = 1'b0;
        continue;
      end
`endif
      if (vn >= TH) begin
        m_v[j]    = 0;
        m_spk[j]  = 1'b1;
        m_refr[j] = REFR_LEN;
      end else begin
        m_v[j]   = vn;
        m_spk[j] = 1'b0;
      end
    end
  endfunction

  // Model advances on the same edges the DUT samples.
  always @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int j = 0; j < N; j++) m_w[r][j] = 0;
      for (int j = 0; j < N; j++) begin
        m_v[j]    = 0;
        m_refr[j] = 0;
      end
      m_spk = '0;
      m_pre = '0;
      m_cnt = 0;
    end else if (m_cnt == 0) begin
      if (flush_weight) begin
        for (int r = 0; r < ROWS; r++)
          for (int j = 0; j < N; j++) m_w[r][j] = 0;
      end else if (wr_en && int'(wr_row) < ROWS) begin
        m_w[wr_row][wr_col] = int'($signed(wr_data));
      end
      if (step_start) begin
        m_pre = {ein_ext, m_spk};
        m_cnt = 1;
      end
    end else begin
      m_cnt = m_cnt + 1;
      if (m_cnt == STEP_LAT) model_step();
      else if (m_cnt > STEP_LAT) m_cnt = 0;
    end
  end

  // Per-cycle comparison of all outputs (and neuron 0 potential) to the model.
  always @(negedge clock) begin
    if (chk_en) begin
      logic exp_busy;
      logic exp_done;
      int   v0;
      exp_busy = (m_cnt >= 1) && (m_cnt <= STEP_LAT - 1);
      exp_done = (m_cnt == STEP_LAT);
      v0       = int'(dut.g_neuron[0].u_neuron.v);
      n_cmp++;
      if (busy !== exp_busy || step_done !== exp_done ||
          spike_record !== m_spk || v0 != m_v[0]) begin
        n_fail++;
        $display("FAIL cycle t=%0t busy=%b exp=%b done=%b exp=%b spikes=%h exp=%h v0=%0d exp=%0d",
                 $time, busy, exp_busy, step_done, exp_done, spike_record, m_spk, v0, m_v[0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic write_w(input int row, input int col, input int data);
    wr_en   = 1'b1;
    wr_row  = 5'(row);
    wr_col  = 4'(col);
    wr_data = 8'(data);
    @(posedge clock);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic flush_w();
    flush_weight = 1'b1;
    @(posedge clock);
    #1;
    flush_weight = 1'b0;
  endtask

  // Start a step, count edges until step_done (bounded), then return to IDLE.
  task automatic run_step(input logic [7:0] ein, output int lat);
    ein_ext    = ein;
    step_start = 1'b1;
    @(posedge clock);
    #1;
    step_start = 1'b0;
    ein_ext    = '0;
    lat        = 1;
    while (step_done !== 1'b1 && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
    end
    $display("step ein=%h latency=%0d spikes=%h", ein, lat, spike_record);
    @(posedge clock);
    #1;
  endtask

  int lat;
  int done_seen;
  int exp5 [4];

  initial begin
    // Reset and an empty first step.
    apply_reset();
    chk_en = 1'b1;
    chk("reset_spikes", int'(spike_record), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(step_done), 0);
    run_step(8'h00, lat);
    chk("empty_latency", lat, 26);
    chk("empty_spikes", int'(spike_record), 0);

    // Single external drive then recurrence into neuron 9.
    write_w(16, 5, 100);
    run_step(8'h01, lat);
    chk("single_latency", lat, 26);
    chk("single_spikes", int'(spike_record), 'h0020);
    write_w(5, 9, 100);
    run_step(8'h00, lat);
    chk("recur_spikes", int'(spike_record), 'h0200);

    // Neuron 5 under constant drive across four steps.
    apply_reset();
    write_w(16, 5, 100);
    write_w(5, 9, 100);
`ifdef RESERVOIR_REFRACTORY_EN
    exp5 = '{1, 0, 0, 1};
`else
    exp5 = '{1, 1, 1, 1};
`endif
    for (int s = 0; s < 4; s++) begin
      run_step(8'h01, lat);
      chk("drive5_bit", int'(spike_record[5]), exp5[s]);
    end

    // Leak: 40 then 40 - 5.
    apply_reset();
    write_w(16, 0, 40);
    run_step(8'h01, lat);
    chk("leak_v_1", int'(dut.g_neuron[0].u_neuron.v), 40);
    chk("leak_spk_1", int'(spike_record), 0);
    run_step(8'h00, lat);
    chk("leak_v_2", int'(dut.g_neuron[0].u_neuron.v), 35);
    chk("leak_spk_2", int'(spike_record), 0);

    // Saturation: every row drives neuron 0 with -128.
    apply_reset();
    for (int j = 0; j < N; j++) write_w(16, j, 100);
    run_step(8'h01, lat);
    chk("sat_all_fire", int'(spike_record), 'hFFFF);
    for (int r = 0; r < ROWS; r++) write_w(r, 0, -128);
    run_step(8'hFF, lat);
    chk("sat_v_1", int'(dut.g_neuron[0].u_neuron.v), -2048);
    chk("sat_spk0_1", int'(spike_record[0]), 0);
    run_step(8'hFF, lat);
    chk("sat_v_2", int'(dut.g_neuron[0].u_neuron.v), -2048);
    flush_w();
    write_w(16, 0, 100);
    run_step(8'h01, lat);
    chk("sat_recover_v", int'(dut.g_neuron[0].u_neuron.v), -1692);

    // Protocol: writes, flush and start during ACCUM are ignored.
    apply_reset();
    write_w(16, 5, 100);
    ein_ext    = 8'h01;
    step_start = 1'b1;
    @(posedge clock);
    #1;
    step_start = 1'b0;
    ein_ext    = '0;
    lat        = 1;
    while (step_done !== 1'b1 && lat < 60) begin
      wr_en        = (lat == 5);
      wr_row       = 5'd16;
      wr_col       = 4'd5;
      wr_data      = 8'(-100);
      flush_weight = (lat == 6);
      step_start   = (lat == 7);
      ein_ext      = (lat == 7) ? 8'hFF : 8'h00;
      @(posedge clock);
      #1;
      lat++;
    end
    wr_en        = 1'b0;
    flush_weight = 1'b0;
    step_start   = 1'b0;
    ein_ext      = '0;
    chk("proto_latency", lat, 26);
    chk("proto_spikes", int'(spike_record), 'h0020);
    @(posedge clock);
    #1;
    run_step(8'h01, lat);
`ifdef RESERVOIR_REFRACTORY_EN
    chk("proto_weight_kept", int'(spike_record), 'h0000);
`else
    chk("proto_weight_kept", int'(spike_record), 'h0020);
`endif

    // Reset mid-ACCUM aborts the step without step_done.
    ein_ext    = 8'h01;
    step_start = 1'b1;
    @(posedge clock);
    #1;
    step_start = 1'b0;
    ein_ext    = '0;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    chk("mid_busy_before", int'(busy), 1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk("mid_busy_after", int'(busy), 0);
    chk("mid_spikes_after", int'(spike_record), 0);
    done_seen = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (step_done === 1'b1) done_seen++;
    end
    chk("mid_no_done", done_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
